// File: rtl/fetch_pkg.sv
// Shared widths and state encoding for the instruction fetch sequencer.
package fetch_pkg;

    localparam int DEF_ADDR_W      = 18;
    localparam int DEF_INSTR_W     = 18;
    localparam int DEF_MEM_TIMEOUT = 255;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PC_RD    = 3'd1,
        PC_CAP   = 3'd2,
        MEM_WAIT = 3'd3,
        HOLD     = 3'd4,
        REDIR    = 3'd5,
        FAULT    = 3'd6
    } fetch_state_e;

endpackage

// File: rtl/fetch_wdog.sv
// Memory-wait watchdog: counts enabled cycles and flags the last one before timeout.
module fetch_wdog #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic expired
);

    generate
        if (MEM_TIMEOUT == 0) begin : g_off
            logic unused_s;
            assign unused_s = ^{clk, rst, enable, clear};
            assign expired  = 1'b0;
        end else begin : g_on
            localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
            localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);
            logic [CW-1:0] cnt_q;

            // Count cycles spent waiting; restart on every ack or exit.
            always_ff @(posedge clk) begin
                if (rst || clear) begin
                    cnt_q <= '0;
                end else if (enable) begin
                    cnt_q <= cnt_q + CW'(1);
                end else begin
                    cnt_q <= cnt_q;
                end
            end

            assign expired = enable && (cnt_q == LAST);
        end
    endgenerate

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: strobes the PC, reads instruction memory and
// hands each word to the decoder, with branch redirects and a timeout fault.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int INSTR_W     = DEF_INSTR_W,
    parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    output logic               pc_re,
    output logic               pc_wr,
    output logic               pc_inc,
    output logic [ADDR_W-1:0]  pc_target,
    input  logic [ADDR_W-1:0]  pc_value,
    output logic               mem_rd,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_data,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_addr,
    output logic               fetch_fault
);

    fetch_state_e       state_q, state_d;
    logic               pc_re_q, pc_wr_q, pc_inc_q, mem_rd_q, hold_q, fault_q, pend_q;
    logic [ADDR_W-1:0]  mem_addr_q, pc_target_q;
    logic [INSTR_W-1:0] instr_q;
    logic               redir_hit_s, wd_en_s, wd_clear_s, wd_expired_s;

    // A redirect seen at any point of the memory wait spoils the returning word.
    assign redir_hit_s = redirect || pend_q;
    assign wd_en_s     = (state_q == MEM_WAIT);
    assign wd_clear_s  = wd_en_s && (state_d != MEM_WAIT);

    fetch_wdog #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .enable (wd_en_s),
        .clear  (wd_clear_s),
        .expired(wd_expired_s)
    );

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (redirect)  state_d = REDIR;
                else if (run)  state_d = PC_RD;
                else           state_d = IDLE;
            end
            PC_RD: begin
                if (redirect) state_d = REDIR;
                else          state_d = PC_CAP;
            end
            PC_CAP: begin
                if (redirect) state_d = REDIR;
                else          state_d = MEM_WAIT;
            end
            MEM_WAIT: begin
                if (mem_ack)           state_d = redir_hit_s ? REDIR : HOLD;
                else if (wd_expired_s) state_d = FAULT;
                else                   state_d = MEM_WAIT;
            end
            HOLD: begin
                if (redirect)         state_d = REDIR;
                else if (instr_ready) state_d = run ? PC_RD : IDLE;
                else                  state_d = HOLD;
            end
            REDIR: begin
                if (redirect) state_d = REDIR;
                else          state_d = PC_RD;
            end
            FAULT:   state_d = FAULT;
            default: state_d = IDLE;
        endcase
    end

    // State register with outputs registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pc_re_q     <= 1'b0;
            pc_wr_q     <= 1'b0;
            pc_inc_q    <= 1'b0;
            mem_rd_q    <= 1'b0;
            hold_q      <= 1'b0;
            fault_q     <= 1'b0;
            pend_q      <= 1'b0;
            mem_addr_q  <= '0;
            pc_target_q <= '0;
            instr_q     <= '0;
        end else begin
            state_q  <= state_d;
            pc_re_q  <= (state_d == PC_RD);
            pc_wr_q  <= (state_d == REDIR);
            pc_inc_q <= (state_d == HOLD) && (state_q != HOLD);
            mem_rd_q <= (state_d == MEM_WAIT);
            hold_q   <= (state_d == HOLD);
            fault_q  <= (state_d == FAULT);
            pend_q   <= (state_d == MEM_WAIT) && redir_hit_s;
            if (redirect && (state_q != FAULT)) pc_target_q <= redirect_addr;
            if (state_q == PC_CAP) mem_addr_q <= pc_value;
            if ((state_q == MEM_WAIT) && mem_ack && !redir_hit_s) instr_q <= mem_data;
        end
    end

    assign pc_re       = pc_re_q;
    assign pc_wr       = pc_wr_q;
    assign pc_inc      = pc_inc_q;
    assign pc_target   = pc_target_q;
    assign mem_rd      = mem_rd_q;
    assign mem_addr    = mem_addr_q;
    assign instr       = instr_q;
    assign instr_valid = hold_q && !redirect;
    assign fetch_fault = fault_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed fetch/redirect/timeout sequences plus random
// traffic checked against a program-order scoreboard, PC model and memory model.
module tb_fetch_ctrl;

    localparam int AW  = 18;
    localparam int IW  = 18;
    localparam int TMO = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1, run = 1'b0, instr_ready = 1'b0, redirect = 1'b0, mem_ack = 1'b0;
    logic [AW-1:0] redirect_addr = '0, pc_value = '0;
    logic [IW-1:0] mem_data = '0;
    logic          pc_re, pc_wr, pc_inc, mem_rd, instr_valid, fetch_fault;
    logic [AW-1:0] pc_target, mem_addr;
    logic [IW-1:0] instr;

    fetch_ctrl #(.ADDR_W(AW), .INSTR_W(IW), .MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .run(run),
        .pc_re(pc_re), .pc_wr(pc_wr), .pc_inc(pc_inc), .pc_target(pc_target), .pc_value(pc_value),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
        .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .redirect(redirect), .redirect_addr(redirect_addr), .fetch_fault(fetch_fault)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Instruction memory contents as a function of address.
    function automatic logic [IW-1:0] memfn(input logic [AW-1:0] a);
        return (a * 18'h00A3B) ^ 18'h2A5A5;
    endfunction

    // Reference state: PC register, memory latency, program-order expectation.
    logic [AW-1:0] pc_m = '0, exp_addr = '0, last_ra = '0, p_addr = '0, s_pc_target = '0;
    logic holding = 1'b0, req_dirty = 1'b0, sb_on = 1'b1, mem_hang = 1'b0;
    logic p_mem_rd = 1'b0, p_ack = 1'b0, p_redir = 1'b0, p_clean = 1'b0, p_dirty = 1'b0;
    logic s_pc_re = 1'b0, s_pc_wr = 1'b0, s_pc_inc = 1'b0, s_mem_rd = 1'b0, s_valid = 1'b0;
    int   fixed_dly = 0, dly = 0, wait_n = 0;

    task automatic cyc(input logic r_rst, input logic r_run, input logic r_rdy,
                       input logic r_redir, input logic [AW-1:0] r_ra);
        logic clean, dirty, xfer;
        @(posedge clk);
        #1;
        if (rst)           pc_m = '0;
        else if (s_pc_wr)  pc_m = s_pc_target;
        else if (s_pc_inc) pc_m = pc_m + 18'd1;
        pc_value = (s_pc_re && !rst) ? pc_m : AW'($urandom);
        if (mem_rd) begin
            if (wait_n == 0) dly = (fixed_dly >= 0) ? fixed_dly : int'($urandom_range(0, 3));
            mem_ack  = !mem_hang && (wait_n == dly);
            mem_data = mem_ack ? memfn(mem_addr) : IW'($urandom);
        end else begin
            mem_ack  = 1'b0;
            mem_data = IW'($urandom);
        end
        rst = r_rst; run = r_run; instr_ready = r_rdy; redirect = r_redir; redirect_addr = r_ra;
        #4;
        s_pc_re = pc_re; s_pc_wr = pc_wr; s_pc_inc = pc_inc; s_pc_target = pc_target;
        s_mem_rd = mem_rd; s_valid = instr_valid;
        xfer = instr_valid && instr_ready;
        if (!r_rst) begin
            check("excl", 32'($countones({pc_re, pc_wr, pc_inc}) <= 1), 32'd1);
            if (sb_on) begin
                check("fault", 32'(fetch_fault), 32'd0);
                check("inc", 32'(pc_inc), 32'(p_clean));
                check("wr", 32'(pc_wr), 32'((p_redir && !(p_mem_rd && !p_ack)) || p_dirty));
                if (pc_wr) check("tgt", 32'(pc_target), 32'(last_ra));
                check("valid", 32'(instr_valid), 32'(holding && !redirect));
                if (p_mem_rd && !p_ack) check("rd_hold", 32'({mem_rd, mem_addr}), 32'({1'b1, p_addr}));
                if (p_mem_rd && p_ack) check("rd_drop", 32'(mem_rd), 32'd0);
                if (mem_rd && !p_mem_rd) check("maddr", 32'(mem_addr), 32'(exp_addr));
                if (xfer) check("xfer", 32'(instr), 32'(memfn(exp_addr)));
            end
        end
        if (r_rst) begin
            exp_addr = '0; last_ra = '0; holding = 1'b0; req_dirty = 1'b0; wait_n = 0;
            p_mem_rd = 1'b0; p_ack = 1'b0; p_redir = 1'b0; p_clean = 1'b0; p_dirty = 1'b0;
        end else begin
            clean = mem_rd && mem_ack && !(req_dirty || redirect);
            dirty = mem_rd && mem_ack && (req_dirty || redirect);
            if (xfer) begin
                exp_addr = exp_addr + 18'd1;
                holding  = 1'b0;
            end
            if (redirect && sb_on) begin
                exp_addr = redirect_addr;
                last_ra  = redirect_addr;
                holding  = 1'b0;
            end
            if (clean) holding = 1'b1;
            req_dirty = (mem_rd && !mem_ack) ? (req_dirty || redirect) : 1'b0;
            wait_n    = (mem_rd && !mem_ack) ? wait_n + 1 : 0;
            p_mem_rd = mem_rd; p_ack = mem_ack; p_redir = redirect;
            p_clean = clean; p_dirty = dirty; p_addr = mem_addr;
        end
    endtask

    // Run cycles (run=1, no redirect) until pc_re, a new mem_rd, or instr_valid.
    task automatic wait_for(input int what, input logic rdy, input string tag);
        logic hit, prev_rd;
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            prev_rd = s_mem_rd;
            cyc(1'b0, 1'b1, rdy, 1'b0, '0);
            case (what)
                0:       hit = s_pc_re;
                1:       hit = s_mem_rd && !prev_rd;
                default: hit = s_valid;
            endcase
        end
        check(tag, 32'(hit), 32'd1);
    endtask

    initial begin
        logic [12:0]   re_v, rd_v, v_v, inc_v;
        logic [AW-1:0] ad_v [13];
        logic [IW-1:0] in_v [13];
        logic [IW-1:0] first_instr;
        logic          ok, vseen, wseen;
        logic [AW-1:0] tgt_seen;
        int            inc_cnt, re_cnt, n;

        // Reset values.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, '0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, '0);
        check("rst_ctl", 32'({pc_re, pc_wr, pc_inc, mem_rd, instr_valid, fetch_fault}), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_instr", 32'(instr), 32'd0);
        check("rst_tgt", 32'(pc_target), 32'd0);

        // Zero-wait memory, three back-to-back fetches from PC 0.
        fixed_dly = 0;
        for (int i = 0; i < 13; i++) begin
            cyc(1'b0, 1'b1, 1'b1, 1'b0, '0);
            re_v[i] = pc_re; rd_v[i] = mem_rd; v_v[i] = instr_valid; inc_v[i] = pc_inc;
            ad_v[i] = mem_addr; in_v[i] = instr;
        end
        check("a_re", 32'(re_v[2:0]), 32'b010);
        check("a_rd3", 32'({rd_v[3], rd_v[2]}), 32'b10);
        check("a_addr0", 32'(ad_v[3]), 32'h00000);
        check("a_val4", 32'({v_v[4], v_v[3]}), 32'b10);
        check("a_instr", 32'(in_v[4]), 32'h2A5A5);
        check("a_inc4", 32'({inc_v[5], inc_v[4]}), 32'b01);
        check("a_addr1", 32'({rd_v[7], ad_v[7]}), 32'({1'b1, 18'h00001}));
        check("a_addr2", 32'({rd_v[11], ad_v[11]}), 32'({1'b1, 18'h00002}));
        check("a_vcnt", 32'($countones(v_v)), 32'd3);

        // Decoder stalls for five cycles in HOLD.
        wait_for(2, 1'b0, "b_wait");
        first_instr = instr; inc_cnt = int'(pc_inc); re_cnt = int'(pc_re); ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
            ok = ok && instr_valid && (instr == first_instr);
            inc_cnt += int'(pc_inc); re_cnt += int'(pc_re);
        end
        check("b_stable", 32'(ok), 32'd1);
        check("b_inc", 32'(inc_cnt), 32'd1);
        check("b_nore", 32'(re_cnt), 32'd0);
        check("b_instr", 32'(first_instr), 32'(memfn(18'h00003)));
        cyc(1'b0, 1'b1, 1'b1, 1'b0, '0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, '0);
        check("b_re", 32'(pc_re), 32'd1);

        // Redirect in the first MEM_WAIT cycle, ack three cycles later.
        fixed_dly = 3;
        cyc(1'b0, 1'b1, 1'b1, 1'b0, '0);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 18'h1F000);
        vseen = 1'b0; wseen = 1'b0; tgt_seen = '0;
        for (int i = 0; i < 10 && !wseen; i++) begin
            cyc(1'b0, 1'b1, 1'b1, 1'b0, '0);
            vseen = vseen || instr_valid;
            wseen = pc_wr;
            tgt_seen = pc_target;
        end
        check("c_novalid", 32'(vseen), 32'd0);
        check("c_wr", 32'(wseen), 32'd1);
        check("c_tgt", 32'(tgt_seen), 32'h1F000);
        wait_for(1, 1'b1, "c_rd");
        check("c_addr", 32'(mem_addr), 32'h1F000);

        // Redirect and instr_ready together in HOLD; target at the top of the space.
        fixed_dly = -1;
        wait_for(2, 1'b0, "d_wait");
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 18'h3FFFF);
        check("d_valid", 32'(instr_valid), 32'd0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, '0);
        check("d_wr", 32'({pc_wr, pc_target}), 32'({1'b1, 18'h3FFFF}));
        wait_for(1, 1'b1, "d_rd");
        check("d_addr", 32'(mem_addr), 32'h3FFFF);
        wait_for(2, 1'b1, "d_xfer");
        check("d_instr", 32'(instr), 32'(memfn(18'h3FFFF)));
        wait_for(1, 1'b1, "d_wrap");
        check("d_wrap_addr", 32'(mem_addr), 32'h00000);

        // Random traffic against the scoreboard.
        for (int i = 0; i < 1500; i++) begin
            cyc(1'b0, $urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7,
                $urandom_range(0, 19) == 0,
                ($urandom_range(0, 7) == 0) ? 18'h3FFFF : AW'($urandom));
        end

        // Memory never acks: timeout, sticky fault, redirect ignored, rst clears.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, '0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, '0);
        sb_on = 1'b0; mem_hang = 1'b1;
        wait_for(1, 1'b1, "e_rd");
        n = 1;
        for (int i = 0; i < 20 && s_mem_rd; i++) begin
            cyc(1'b0, 1'b1, 1'b1, 1'b0, '0);
            if (s_mem_rd) n++;
        end
        check("e_wait", 32'(n), 32'(TMO));
        check("e_fault", 32'({fetch_fault, mem_rd}), 32'b10);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 18'h12345);
        ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, 1'b1, 1'b0, '0);
            ok = ok && fetch_fault && !pc_wr && !pc_re && !mem_rd && !instr_valid;
        end
        check("e_sticky", 32'(ok), 32'd1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, '0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, '0);
        check("e_clear", 32'({fetch_fault, pc_re, mem_rd}), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
